// File: rtl/out_channel_checker.sv
// Out-channel receiver: captures program `out` words into a circular buffer, then
// compares them one per cycle against a loadable expected table and reports pass/fail.
module out_channel_checker #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 12,
  parameter int NExpected          = 12,
  localparam int ExpAddrWidth      = (NExpected > 1) ? $clog2(NExpected) : 1,
  localparam int PosWidth          = (NOut > 1) ? $clog2(NOut) : 1,
  localparam int MismatchWidth     = $clog2(NOut) + 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [MemoryElementWidth-1:0] in_data,
  output logic                          in_ready,
  input  logic                          prog_done,
  input  logic                          exp_we,
  input  logic [ExpAddrWidth-1:0]       exp_addr,
  input  logic [MemoryElementWidth-1:0] exp_data,
  output logic                          finished,
  output logic                          success,
  output logic [15:0]                   received,
  output logic [MismatchWidth-1:0]      mismatch_index
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_CHECK   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]                    state;
  logic [PosWidth-1:0]           pos;
  logic [PosWidth-1:0]           idx;
  logic [MemoryElementWidth-1:0] buffer    [NOut];
  logic [MemoryElementWidth-1:0] exp_table [NExpected];

  logic transfer;
  logic restart;

  assign in_ready = (state == S_COLLECT);
  assign finished = (state == S_DONE);
  assign transfer = in_valid & in_ready;
  assign restart  = start & (state != S_CHECK);
  assign success  = finished && (mismatch_index == '1) && (received == 16'(NExpected));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order within the block.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      pos            <= '0;
      idx            <= '0;
      received       <= '0;
      mismatch_index <= '1;
    end else if (restart) begin
      state          <= S_COLLECT;
      pos            <= '0;
      received       <= '0;
      mismatch_index <= '1;
    end else begin
      case (state)
        S_COLLECT: begin
          // A transfer coinciding with prog_done is still captured below.
          if (transfer) begin
            pos <= (pos == PosWidth'(NOut - 1)) ? '0 : pos + 1'b1;
            if (received != 16'hFFFF) received <= received + 16'd1;
          end
          if (prog_done) begin
            state <= S_CHECK;
            idx   <= '0;
          end
        end
        S_CHECK: begin
          if ((buffer[idx] != exp_table[idx[ExpAddrWidth-1:0]]) && (mismatch_index == '1))
            mismatch_index <= MismatchWidth'(idx);
          if (idx == PosWidth'(NExpected - 1)) state <= S_DONE;
          else                                 idx   <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the arrays carry no reset; start zeroes the capture buffer, and the
  // expected table must deliberately survive reset.
  always_ff @(posedge clock) begin
    if (!reset && restart) begin
      for (int i = 0; i < NOut; i++) buffer[i] <= '0;
    end else if (!reset && transfer) begin
      buffer[pos] <= in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (exp_we && ((state == S_IDLE) || (state == S_DONE)))
      exp_table[exp_addr] <= exp_data;
  end

endmodule
